// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// ALU operation codes, instruction field codes and condition codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    // Instruction class (op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Data-processing cmd field
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       reg_write_ok;
    } cmd_dec_t;

    // Unknown commands run as ADD but must not write the register file.
    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
        cmd_dec_t d;
        d.alu_control  = ALU_ADD;
        d.reg_write_ok = 1'b1;
        case (cmd)
            CMD_ADD:          d.alu_control = ALU_ADD;
            CMD_SUB, CMD_CMP: d.alu_control = ALU_SUB;
            CMD_AND:          d.alu_control = ALU_AND;
            CMD_ORR:          d.alu_control = ALU_ORR;
            default:          d.reg_write_ok = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller view, slave = datapath view.
interface mc_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        AdrSrc;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  RegSrc;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic        Busy;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, RegSrc, ImmSrc, ALUControl, Busy
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, RegSrc, ImmSrc, ALUControl, Busy
    );
endinterface

// File: rtl/mc_controller_cond_unit.sv
// Flag register plus combinational condition evaluation against the
// stored NZCV flags.
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_write,
    output logic       cond_ex
);

    logic [3:0] flags_reg;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_reg;

    // Capture ALU flags at the end of a flag-writing cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags_reg <= 4'b0000;
        else if (flag_write)
            flags_reg <= alu_flags;
    end

    // Evaluate the condition field against the stored flags
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: main FSM sequencing fetch, decode,
// memory, data-processing and branch phases, with conditional execution.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);

    state_t     state_reg, state_next;

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       i_bit, s_bit, u_bit, l_bit;
    logic       cond_ex, flag_write;
    cmd_dec_t   cmd_dec;
    logic       unused_bits;

    logic       pc_write, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;

    // Instruction fields (Instr holds bits [31:12])
    assign cond  = bus.Instr[19:16];
    assign op    = bus.Instr[15:14];
    assign i_bit = bus.Instr[13];
    assign cmd   = bus.Instr[12:9];
    assign s_bit = bus.Instr[8];
    assign u_bit = bus.Instr[11];
    assign l_bit = bus.Instr[8];
    assign rd    = bus.Instr[3:0];
    assign unused_bits = ^{bus.Instr[10], bus.Instr[7:4]};

    assign cmd_dec = decode_cmd(cmd);

    cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (bus.ALUFlags),
        .flag_write (flag_write),
        .cond_ex    (cond_ex)
    );

    // State register; reset drops back to FETCH immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    // Next-state selection
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (bus.MemReady) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = i_bit ? S_EXECI : S_EXECR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = l_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.MemReady) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (bus.MemReady) state_next = S_FETCH;
            S_EXECR, S_EXECI:
                state_next = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; architectural writes gated by cond_ex
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        flag_write  = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state_reg)
            S_FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.MemReady;
                pc_write   = bus.MemReady;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: begin
                alu_src_b   = 2'b01;
                alu_control = u_bit ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: begin
                adr_src    = 1'b1;
                result_src = 2'b00;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex;
                pc_write   = cond_ex & (rd == 4'd15);
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (state_reg == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = cmd_dec.alu_control;
                flag_write  = s_bit & cond_ex;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = cond_ex & cmd_dec.reg_write_ok;
                pc_write   = cond_ex & (rd == 4'd15);
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
    end

    // Enables are forced low for as long as reset is held
    assign bus.PCWrite    = reset & pc_write;
    assign bus.IRWrite    = reset & ir_write;
    assign bus.MemWrite   = reset & mem_write;
    assign bus.RegWrite   = reset & reg_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {(op == OP_MEM) & ~l_bit, (op == OP_BR)};
    assign bus.Busy       = (state_reg != S_FETCH);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction scenarios plus random
// instructions and MemReady patterns, checked against a per-instruction
// cycle/event model.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mc_controller_if bus();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    bit         rdy[64];
    logic [3:0] model_flags = 4'b0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] cnd, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cnd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int first_ready(input int from);
        for (int i = from; i < 64; i++)
            if (rdy[i]) return i;
        return 63;
    endfunction

    task automatic rdy_all_ones();
        for (int i = 0; i < 64; i++) rdy[i] = 1'b1;
    endtask

    task automatic rdy_random();
        for (int i = 0; i < 64; i++)
            rdy[i] = (i >= 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
    endtask

    // Runs one instruction from a FETCH cycle (entered at posedge+1) until
    // the controller is back in FETCH, then compares against the model.
    task automatic run_instr(input logic [31:0] word, input logic [3:0] aluf, input string name);
        logic [19:0] ins;
        logic [3:0]  cnd, cmd, rd, new_flags;
        logic [1:0]  op, exp_b;
        logic [2:0]  exp_alu;
        bit          ibit, sbit, ubit, lbit, cex, supported, is_cmp, done, seen;
        int          tf, tm, total, exp_reg, exp_mem, exp_pc, cycles, reg_at;
        int          n_reg, n_mem, n_pc, n_ir;

        ins  = word[31:12];
        cnd  = ins[19:16];
        op   = ins[15:14];
        ibit = ins[13];
        cmd  = ins[12:9];
        sbit = ins[8];
        ubit = ins[11];
        lbit = ins[8];
        rd   = ins[3:0];
        cex  = cond_holds(cnd, model_flags);
        supported = (cmd == 4'd0) || (cmd == 4'd2) || (cmd == 4'd4) || (cmd == 4'd10) || (cmd == 4'd12);
        is_cmp = (cmd == 4'b1010);
        new_flags = model_flags;
        tf = first_ready(0);
        exp_reg = 0; exp_mem = 0; exp_pc = 1; exp_alu = 3'd0; exp_b = 2'b01;
        total = tf + 2;

        case (op)
            2'b00: begin
                total   = is_cmp ? tf + 3 : tf + 4;
                exp_reg = (!is_cmp && cex && supported) ? 1 : 0;
                exp_pc  = 1 + ((!is_cmp && cex && rd == 4'd15) ? 1 : 0);
                exp_b   = ibit ? 2'b01 : 2'b00;
                if (sbit && cex) new_flags = aluf;
                case (cmd)
                    4'b0010, 4'b1010: exp_alu = 3'd1;
                    4'b0000:          exp_alu = 3'd2;
                    4'b1100:          exp_alu = 3'd3;
                    default:          exp_alu = 3'd0;
                endcase
            end
            2'b01: begin
                tm      = first_ready(tf + 3);
                exp_alu = ubit ? 3'd0 : 3'd1;
                if (lbit) begin
                    total   = tm + 2;
                    exp_reg = cex ? 1 : 0;
                    exp_pc  = 1 + ((cex && rd == 4'd15) ? 1 : 0);
                end else begin
                    total   = tm + 1;
                    exp_mem = cex ? (tm - tf - 2) : 0;
                end
            end
            2'b10: begin
                total  = tf + 3;
                exp_pc = 1 + (cex ? 1 : 0);
            end
            default: total = tf + 2;
        endcase

        bus.Instr    = ins;
        bus.ALUFlags = aluf;
        bus.MemReady = rdy[0];
        n_reg = 0; n_mem = 0; n_pc = 0; n_ir = 0;
        done = 0; seen = 0; cycles = -1; reg_at = -1;

        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (seen && !bus.Busy) begin
                done = 1;
                cycles = c;
                bus.MemReady = 1'b0;
                break;
            end
            if (bus.Busy) seen = 1;
            if (c == 0) begin
                chk({name, " immsrc"}, bus.ImmSrc, op);
                chk({name, " regsrc"}, bus.RegSrc, {(op == 2'b01) && !lbit, op == 2'b10});
            end
            if (c < total) chk({name, " busy"}, bus.Busy, (c > tf));
            if (bus.RegWrite) begin n_reg++; reg_at = c; end
            if (bus.MemWrite) n_mem++;
            if (bus.PCWrite)  n_pc++;
            if (bus.IRWrite)  n_ir++;
            if (c == tf + 1)
                chk({name, " decode_mux"}, {bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl},
                    {2'b01, 2'b10, 2'b10, 3'b000});
            if (c == tf + 2 && op != 2'b11)
                chk({name, " exec_mux"}, {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}, {2'b00, exp_b, exp_alu});
            if (op == 2'b01 && c == tf + 3)
                chk({name, " adrsrc"}, bus.AdrSrc, 1'b1);
            if (c == total - 1 && ((op == 2'b00 && !is_cmp) || (op == 2'b01 && lbit)))
                chk({name, " wb_resultsrc"}, bus.ResultSrc, (op == 2'b01) ? 2'b01 : 2'b00);
            @(posedge clk);
            #1;
            bus.MemReady = (c + 1 < 64) ? rdy[c + 1] : 1'b1;
        end

        if (!done) chk({name, " return_to_fetch"}, 0, 1);
        chk({name, " cycles"}, cycles, total);
        chk({name, " regwrite_cnt"}, n_reg, exp_reg);
        chk({name, " memwrite_cnt"}, n_mem, exp_mem);
        chk({name, " pcwrite_cnt"}, n_pc, exp_pc);
        chk({name, " irwrite_cnt"}, n_ir, 1);
        if (exp_reg == 1) chk({name, " regwrite_at"}, reg_at, total - 1);

        @(posedge clk);
        #1;
        model_flags = new_flags;
        $display("txn %-6s instr=%08h op=%0d condex=%0d cycles=%0d exp=%0d flags=%04b",
                 name, word, op, cex, cycles, total, model_flags);
    endtask

    initial begin
        bus.Instr    = 20'hE0821;
        bus.ALUFlags = 4'b0000;
        bus.MemReady = 1'b1;

        // Held in reset: FETCH enables must stay low even with MemReady high
        #2;
        chk("rst_enables", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 4'b0000);
        chk("rst_busy", bus.Busy, 1'b0);
        @(posedge clk); #1;
        chk("rst_enables_edge", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 4'b0000);
        bus.MemReady = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // ADD R1,R2,R3
        rdy_all_ones();
        run_instr(32'hE0821003, 4'b0000, "add");
        // LDR with three MemReady-low cycles in MEMRD
        rdy[3] = 1'b0; rdy[4] = 1'b0; rdy[5] = 1'b0;
        run_instr(32'hE5921004, 4'b0000, "ldr");
        rdy_all_ones();
        // SUBS -> Z, BEQ taken; SUBS -> Z, BNE not taken
        run_instr(32'hE0511002, 4'b0100, "subs");
        run_instr(32'h0A000000, 4'b0000, "beq");
        run_instr(32'hE0511002, 4'b0100, "subs");
        run_instr(32'h1A000000, 4'b0000, "bne");
        // CMP updates flags without a register write
        run_instr(32'hE1510002, 4'b1000, "cmp");
        run_instr(32'h4A000000, 4'b0000, "bmi");
        // Clear Z, then STR with EQ must not write memory
        run_instr(32'hE0511002, 4'b0000, "subs");
        rdy[3] = 1'b0; rdy[4] = 1'b0;
        run_instr(32'h05821004, 4'b0000, "streq");
        rdy_all_ones();

        // Set Z, then reset during MEMRD
        run_instr(32'hE0511002, 4'b0100, "subs");
        bus.Instr    = 20'hE5921;
        bus.MemReady = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.MemReady = 1'b1;
        chk("memrd_busy", bus.Busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_enables", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 4'b0000);
        chk("midrst_busy", bus.Busy, 1'b0);
        @(posedge clk); #1;
        bus.MemReady = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_flags = 4'b0000;
        @(posedge clk); #1;
        chk("post_rst_fetch", bus.Busy, 1'b0);
        run_instr(32'h0A000000, 4'b0000, "beq0");
        run_instr(32'h1A000000, 4'b0000, "bne0");

        // Random instructions, flags and memory wait patterns
        for (int k = 0; k < 60; k++) begin
            rdy_random();
            run_instr($urandom(), 4'($urandom_range(0, 15)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
